// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Packet-level round-robin sharing of one UART transmit core among
//             NUM_REQ byte-stream requesters. Optional UART_TX_ARB_TAG_EN
//             prefixes each packet with tag byte 8'hA0 | grant_id.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int HOLD_TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 grant_valid,
    output logic [ID_W-1:0]      grant_id,
    output logic                 timeout_pulse
);

    localparam logic [2:0] c_ARB     = 3'd0;
    localparam logic [2:0] c_ACCEPT  = 3'd1;
    localparam logic [2:0] c_ISSUE   = 3'd2;
    localparam logic [2:0] c_WAIT_HI = 3'd3;
    localparam logic [2:0] c_WAIT_LO = 3'd4;
    localparam logic [2:0] c_HOLD    = 3'd5;
    localparam logic [2:0] c_TAG     = 3'd6;

    // Firing one count early makes the pulse land HOLD_TIMEOUT cycles after busy falls.
    localparam logic [15:0] c_HOLD_FIRE = 16'(HOLD_TIMEOUT - 2);
    localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(NUM_REQ - 1);

    logic [2:0]         r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_grant_id;
    logic               r_grant_valid;
    logic [NUM_REQ-1:0] r_ready;
    logic               r_tx_start;
    logic [7:0]         r_tx_data;
    logic               r_timeout;
    logic               r_last;
    logic [15:0]        r_hold_cnt;
`ifdef UART_TX_ARB_TAG_EN
    logic               r_tag_pend;
`endif

    logic               w_hit;
    logic [ID_W-1:0]    w_hit_id;
    logic [NUM_REQ-1:0] w_grant_onehot;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        return ID_W'((int'(base) + off) % NUM_REQ);
    endfunction

    // Scan from the farthest offset down so the nearest requester after rr_ptr wins.
    always_comb begin
        w_hit    = 1'b0;
        w_hit_id = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_valid[wrap_idx(r_rr_ptr, i)]) begin
                w_hit    = 1'b1;
                w_hit_id = wrap_idx(r_rr_ptr, i);
            end
        end
    end

    assign w_grant_onehot = NUM_REQ'(1) << r_grant_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ARB;
            r_rr_ptr      <= c_LAST_ID;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_ready       <= '0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_timeout     <= 1'b0;
            r_last        <= 1'b0;
            r_hold_cnt    <= 16'h0000;
`ifdef UART_TX_ARB_TAG_EN
            r_tag_pend    <= 1'b0;
`endif
        end else begin
            r_ready    <= '0;
            r_tx_start <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                c_ARB: begin
                    if (w_hit) begin
                        r_grant_id    <= w_hit_id;
                        r_grant_valid <= 1'b1;
`ifdef UART_TX_ARB_TAG_EN
                        r_state       <= c_TAG;
`else
                        r_state       <= c_ACCEPT;
                        if (!tx_busy) begin
                            r_ready <= NUM_REQ'(1) << w_hit_id;
                        end
`endif
                    end
                end
                // req_ready is high during the ACCEPT cycle; data is taken at its closing edge.
                c_ACCEPT: begin
                    if (r_ready != '0) begin
                        r_tx_data  <= req_data[8*r_grant_id +: 8];
                        r_last     <= req_last[r_grant_id];
                        r_tx_start <= 1'b1;
                        r_state    <= c_ISSUE;
                    end else if (!tx_busy) begin
                        r_ready <= w_grant_onehot;
                    end
                end
                c_ISSUE: begin
                    r_state <= c_WAIT_HI;
                end
                c_WAIT_HI: begin
                    if (tx_busy) begin
                        r_state <= c_WAIT_LO;
                    end
                end
                c_WAIT_LO: begin
                    if (!tx_busy) begin
`ifdef UART_TX_ARB_TAG_EN
                        if (r_tag_pend) begin
                            r_tag_pend <= 1'b0;
                            r_ready    <= w_grant_onehot;
                            r_state    <= c_ACCEPT;
                        end else
`endif
                        if (r_last) begin
                            r_rr_ptr      <= r_grant_id;
                            r_grant_valid <= 1'b0;
                            r_grant_id    <= '0;
                            r_state       <= c_ARB;
                        end else begin
                            r_hold_cnt <= 16'h0000;
                            r_state    <= c_HOLD;
                        end
                    end
                end
                c_HOLD: begin
                    if (req_valid[r_grant_id]) begin
                        r_state <= c_ACCEPT;
                        if (!tx_busy) begin
                            r_ready <= w_grant_onehot;
                        end
                    end else if (r_hold_cnt == c_HOLD_FIRE) begin
                        r_timeout     <= 1'b1;
                        r_rr_ptr      <= r_grant_id;
                        r_grant_valid <= 1'b0;
                        r_grant_id    <= '0;
                        r_state       <= c_ARB;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 16'h0001;
                    end
                end
`ifdef UART_TX_ARB_TAG_EN
                c_TAG: begin
                    if (!tx_busy) begin
                        r_tx_data  <= 8'hA0 | 8'(r_grant_id);
                        r_tx_start <= 1'b1;
                        r_tag_pend <= 1'b1;
                        r_state    <= c_ISSUE;
                    end
                end
`endif
                default: begin
                    r_state <= c_ARB;
                end
            endcase
        end
    end

    assign req_ready     = r_ready;
    assign tx_start      = r_tx_start;
    assign tx_data       = r_tx_data;
    assign grant_valid   = r_grant_valid;
    assign grant_id      = r_grant_id;
    assign timeout_pulse = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Self-checking bench for uart_tx_arbiter with a UART core model
//             and a packet-level round-robin reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int ID_W         = 2;
    localparam int HOLD_TIMEOUT = 8;
`ifdef UART_TX_ARB_TAG_EN
    localparam int c_STRIDE = 2;
`else
    localparam int c_STRIDE = 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_last = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_id;
    logic                 timeout_pulse;

    int tests_run    = 0;
    int tests_failed = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .ID_W         (ID_W),
        .HOLD_TIMEOUT (HOLD_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_busy       (tx_busy),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    // UART core model plus line/handshake recorder.
    int                  busy_len = 4;
    int                  busy_cnt;
    logic [ID_W+7:0]     line_q[$];
    int                  ready_cnt [NUM_REQ];
    int                  violations = 0;
    logic [NUM_REQ-1:0]  prev_ready;
    logic                prev_start;
    logic                prev_to;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy    <= 1'b0;
            busy_cnt   <= 0;
            prev_ready <= '0;
            prev_start <= 1'b0;
            prev_to    <= 1'b0;
            line_q.delete();
            for (int i = 0; i < NUM_REQ; i++) ready_cnt[i] <= 0;
        end else begin
            if (tx_start) begin
                tx_busy  <= 1'b1;
                busy_cnt <= busy_len - 1;
                line_q.push_back({grant_id, tx_data});
            end else if (tx_busy) begin
                if (busy_cnt == 0) tx_busy <= 1'b0;
                else busy_cnt <= busy_cnt - 1;
            end
            if ((prev_ready & req_ready) != '0 || $countones(req_ready) > 1 ||
                (prev_start && tx_start) || (prev_to && timeout_pulse))
                violations <= violations + 1;
            for (int i = 0; i < NUM_REQ; i++)
                if (req_ready[i]) ready_cnt[i] <= ready_cnt[i] + 1;
            prev_ready <= req_ready;
            prev_start <= tx_start;
            prev_to    <= timeout_pulse;
        end
    end

    // Requester packet queues: {last, data}; exp_q holds the modelled line.
    logic [8:0]          pq [NUM_REQ][$];
    logic [ID_W+7:0]     exp_q[$];
    int                  exp_bytes [NUM_REQ];
    logic [NUM_REQ-1:0]  pend;

    task automatic drive_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pq[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = pq[i][0][7:0];
                req_last[i]        = pq[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    // Whole packets go out in round-robin order from the reset pointer.
    task automatic build_model();
        logic [8:0] mq [NUM_REQ][$];
        logic [8:0] b;
        int ptr;
        int pick;
        ptr = NUM_REQ - 1;
        exp_q.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            mq[i] = pq[i];
            exp_bytes[i] = pq[i].size();
        end
        forever begin
            pick = -1;
            for (int o = 1; o <= NUM_REQ; o++)
                if (pick < 0 && mq[(ptr + o) % NUM_REQ].size() > 0) pick = (ptr + o) % NUM_REQ;
            if (pick < 0) break;
`ifdef UART_TX_ARB_TAG_EN
            exp_q.push_back({ID_W'(pick), 8'hA0 | 8'(pick)});
`endif
            do begin
                b = mq[pick].pop_front();
                exp_q.push_back({ID_W'(pick), b[7:0]});
            end while (!b[8]);
            ptr = pick;
        end
    endtask

    task automatic run_engine(input int max_cycles, output bit ok);
        int  cyc;
        bit  empty;
        cyc  = 0;
        ok   = 1'b0;
        pend = '0;
        drive_reqs();
        while (cyc < max_cycles) begin
            @(posedge clk); #1;
            cyc++;
            for (int i = 0; i < NUM_REQ; i++)
                if (pend[i]) pq[i].delete(0);
            pend = req_ready;
            drive_reqs();
            empty = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) if (pq[i].size() > 0) empty = 1'b0;
            if (empty && pend == '0 && !grant_valid && !tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        pend      = '0;
        for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        tests_run++;
        if ({req_ready, tx_start, tx_data, grant_valid, grant_id, timeout_pulse} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ready=%b start=%b data=%h gv=%b gid=%0d to=%b, all required 0",
                     req_ready, tx_start, tx_data, grant_valid, grant_id, timeout_pulse);
        end
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (grant_valid !== 1'b0 || tx_start !== 1'b0 || req_ready !== '0) begin
            tests_failed++;
            $display("FAIL idle_no_grant: gv=%b start=%b ready=%b, required 0/0/0", grant_valid, tx_start, req_ready);
        end
    endtask

    task automatic test_single_byte();
        int  n;
        bit  seen;
        do_reset();
        busy_len = 10;
        req_valid[0] = 1'b1; req_data[7:0] = 8'h55; req_last[0] = 1'b1;
`ifdef UART_TX_ARB_TAG_EN
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
`else
        @(posedge clk); #1;
`endif
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL single_ready_latency: req_ready=%b, required 0001", req_ready);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        tests_run++;
        if (tx_start !== 1'b1 || tx_data !== 8'h55 || grant_id !== 2'd0 || grant_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_start: start=%b data=%h gid=%0d gv=%b, required 1/55/0/1",
                     tx_start, tx_data, grant_id, grant_valid);
        end
        n = 0; seen = 1'b0;
        while (n < 60) begin
            @(posedge clk); #1; n++;
            if (tx_busy) seen = 1'b1;
            else if (seen) break;
        end
        tests_run++;
        if (!seen || tx_busy !== 1'b0 || grant_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_busy_fall: seen=%b busy=%b gv=%b, required 1/0/1", seen, tx_busy, grant_valid);
        end
        @(posedge clk); #1;
        tests_run++;
        if (grant_valid !== 1'b0 || ready_cnt[0] !== 1) begin
            tests_failed++;
            $display("FAIL single_release: gv=%b ready_pulses=%0d, required 0/1", grant_valid, ready_cnt[0]);
        end
    endtask

    task automatic test_no_interleave();
        bit ok;
        do_reset();
        busy_len = int'($urandom_range(3, 6));
        pq[1].push_back(9'h011); pq[1].push_back(9'h022); pq[1].push_back(9'h133);
        pq[2].push_back(9'h199);
        build_model();
        run_engine(2000, ok);
        tests_run++;
        if (!ok || line_q.size() != 4 * c_STRIDE) begin
            tests_failed++;
            $display("FAIL interleave_len: done=%b bytes=%0d, required 1/%0d", ok, line_q.size(), 4 * c_STRIDE);
        end else begin
            tests_run++;
            if (line_q[c_STRIDE*3 - 1] !== {2'd1, 8'h33} || line_q[c_STRIDE*4 - 1] !== {2'd2, 8'h99} ||
                line_q[c_STRIDE - 1] !== {2'd1, 8'h11}) begin
                tests_failed++;
                $display("FAIL interleave_order: first=%h third=%h fourth=%h, required 111/133/299",
                         line_q[c_STRIDE-1], line_q[c_STRIDE*3-1], line_q[c_STRIDE*4-1]);
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int bad;
        do_reset();
        busy_len = 3;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_REQ; i++) pq[i].push_back({1'b1, 4'(r), 4'(i)});
        build_model();
        run_engine(3000, ok);
        tests_run++;
        if (!ok || line_q.size() != 8 * c_STRIDE) begin
            tests_failed++;
            $display("FAIL rr_len: done=%b bytes=%0d, required 1/%0d", ok, line_q.size(), 8 * c_STRIDE);
        end else begin
            bad = -1;
            for (int k = 0; k < 8 * c_STRIDE; k++)
                if (bad < 0 && line_q[k][9:8] !== 2'((k / c_STRIDE) % NUM_REQ)) bad = k;
            tests_run++;
            if (bad >= 0) begin
                tests_failed++;
                $display("FAIL rr_order: entry %0d grant=%0d, required %0d", bad, line_q[bad][9:8],
                         (bad / c_STRIDE) % NUM_REQ);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        busy_len = 4;
        req_valid[3] = 1'b1; req_data[31:24] = 8'h77; req_last[3] = 1'b0;
        n = 0;
        while (req_ready[3] !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        n = 0;
        while (tx_busy !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        while (tx_busy !== 1'b0 && n < 60) begin @(posedge clk); #1; n++; end
        req_valid[0] = 1'b1; req_data[7:0] = 8'h05; req_last[0] = 1'b1;
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1; n++;
            if (timeout_pulse === 1'b1) break;
        end
        tests_run++;
        if (n != HOLD_TIMEOUT || grant_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_delay: pulse after %0d cycles gv=%b, required %0d/0", n, grant_valid, HOLD_TIMEOUT);
        end
        @(posedge clk); #1;
        tests_run++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd0 || timeout_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_regrant: gv=%b gid=%0d to=%b, required 1/0/0", grant_valid, grant_id, timeout_pulse);
        end
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        n = 0;
        while (grant_valid !== 1'b0 && n < 60) begin @(posedge clk); #1; n++; end
        tests_run++;
        if (grant_valid !== 1'b0 || line_q.size() != 2 * c_STRIDE) begin
            tests_failed++;
            $display("FAIL timeout_finish: gv=%b bytes=%0d, required 0/%0d", grant_valid, line_q.size(), 2 * c_STRIDE);
        end
    endtask

    task automatic test_reset_mid_packet();
        int n;
        do_reset();
        busy_len = 8;
        req_valid[1] = 1'b1; req_data[15:8] = 8'h31; req_last[1] = 1'b0;
        n = 0;
        while (req_ready[1] !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        while (tx_busy !== 1'b1 && n < 80) begin @(posedge clk); #1; n++; end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({req_ready, tx_start, tx_data, grant_valid, grant_id, timeout_pulse} !== '0 || tx_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: ready=%b start=%b data=%h gv=%b gid=%0d busy=%b, required all 0",
                     req_ready, tx_start, tx_data, grant_valid, grant_id, tx_busy);
        end
        req_valid = 4'b0101; req_last = 4'b0101; req_data = 32'h0033_0011;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_regrant: gv=%b gid=%0d, required 1/0", grant_valid, grant_id);
        end
    endtask

`ifdef UART_TX_ARB_TAG_EN
    task automatic test_tag();
        bit ok;
        do_reset();
        busy_len = 3;
        pq[2].push_back(9'h141);
        run_engine(500, ok);
        tests_run++;
        if (!ok || line_q.size() != 2 || line_q[0] !== {2'd2, 8'hA2} || line_q[1] !== {2'd2, 8'h41} ||
            ready_cnt[2] !== 1) begin
            tests_failed++;
            $display("FAIL tag_bytes: done=%b bytes=%0d ready_pulses=%0d, required 1/2 (A2,41)/1",
                     ok, line_q.size(), ready_cnt[2]);
        end
    endtask
`endif

    task automatic test_random_traffic();
        bit ok;
        int bad;
        int len;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            busy_len = int'($urandom_range(2, 5));
            for (int i = 0; i < NUM_REQ; i++)
                for (int p = 0; p < int'($urandom_range(0, 2)); p++) begin
                    len = int'($urandom_range(1, 3));
                    for (int b = 0; b < len; b++) pq[i].push_back({b == len - 1, 8'($urandom)});
                end
            build_model();
            run_engine(4000, ok);
            tests_run++;
            if (!ok || line_q.size() != exp_q.size()) begin
                tests_failed++;
                $display("FAIL random_len[%0d]: done=%b bytes=%0d, required 1/%0d", it, ok, line_q.size(), exp_q.size());
            end else begin
                bad = -1;
                foreach (exp_q[k]) if (bad < 0 && line_q[k] !== exp_q[k]) bad = k;
                tests_run++;
                if (bad >= 0) begin
                    tests_failed++;
                    $display("FAIL random_stream[%0d]: entry %0d got %h, required %h", it, bad, line_q[bad], exp_q[bad]);
                end
            end
            bad = -1;
            for (int i = 0; i < NUM_REQ; i++) if (bad < 0 && ready_cnt[i] !== exp_bytes[i]) bad = i;
            tests_run++;
            if (bad >= 0) begin
                tests_failed++;
                $display("FAIL random_ready[%0d]: req %0d pulses=%0d, required %0d", it, bad, ready_cnt[bad], exp_bytes[bad]);
            end
        end
    endtask

    task automatic test_pulse_widths();
        tests_run++;
        if (violations != 0) begin
            tests_failed++;
            $display("FAIL pulse_rules: %0d violations, required 0", violations);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_no_interleave();
        test_round_robin();
        test_timeout();
        test_reset_mid_packet();
`ifdef UART_TX_ARB_TAG_EN
        test_tag();
`endif
        test_random_traffic();
        test_pulse_widths();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmit core among NUM_REQ byte-stream requesters using packet-level round-robin arbitration. A grant is held from a requester's first byte until its byte flagged last, so packets never interleave on the line. The block drives the core's tx_start/tx_data pair and sequences each byte off the core's tx_busy. It sits between the debug/telemetry sources and the UART transmit core.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, grant_id width; must be >= clog2(NUM_REQ)
HOLD_TIMEOUT, 65535, max idle cycles mid-packet before grant is forcibly released (16-bit counter)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  8*NUM_REQ  per-requester byte; requester i on bits [8i+7:8i]
req_last  input  NUM_REQ  byte is final byte of packet
req_ready  output  NUM_REQ  one-hot byte-accept pulse
tx_start  output  1  one-cycle start pulse to the transmit core
tx_data  output  8  byte to the transmit core; stable while tx_start high
tx_busy  input  1  transmit core busy
grant_valid  output  1  a requester currently owns the line
grant_id  output  ID_W  index of owning requester (0 when grant_valid low)
timeout_pulse  output  1  one-cycle pulse when a grant is forcibly released

Behaviour:
- Reset (async): state=ARB, rr_ptr=NUM_REQ-1, req_ready=0, tx_start=0, tx_data=0, grant_valid=0, grant_id=0, timeout_pulse=0, hold counter=0, byte/last registers=0.
- States: ARB, ACCEPT, ISSUE, WAIT_HI, WAIT_LO, HOLD.
- ARB: search req_valid starting at rr_ptr+1 with modulo NUM_REQ wrap; first hit wins. On a hit, register grant_id, set grant_valid=1, go to ACCEPT. On no hit, stay in ARB.
- ACCEPT: assert req_ready[grant_id] for exactly one cycle. Capture req_data and req_last of grant_id into internal registers. Go to ISSUE.
- ISSUE: tx_start=1 for one cycle with tx_data = captured byte. Only entered when tx_busy=0. Go to WAIT_HI.
- WAIT_HI: wait until tx_busy=1, then go to WAIT_LO. The core raises busy the cycle after start.
- WAIT_LO: wait until tx_busy=0.
  - If captured last=1: rr_ptr<=grant_id, grant_valid<=0, grant_id<=0, go to ARB.
  - Otherwise: clear hold counter, go to HOLD.
- HOLD:
  - If req_valid[grant_id]=1, go to ACCEPT. Other requesters' valids are ignored.
  - Otherwise increment hold counter.
  - When counter reaches HOLD_TIMEOUT-1 with no valid: pulse timeout_pulse, rr_ptr<=grant_id, drop grant, go to ARB.
- Latency: a valid byte in ARB gives req_ready 1 cycle later and tx_start 2 cycles later. Back-to-back bytes of one packet: next tx_start follows tx_busy falling by 3 cycles (HOLD, ACCEPT, ISSUE).
- Boundary conditions:
  - All requesters valid: grants rotate 0,1,2,3,0 after reset.
  - A single requester re-requesting immediately after its last byte is regranted once no other requester is valid.
  - req_valid dropping while in ACCEPT is a protocol violation by the requester; behaviour is undefined.
  - tx_busy already high on entry to ARB: arbitration proceeds, but ISSUE is not entered until tx_busy=0. ACCEPT waits in place with req_ready low until tx_busy=0, then pulses.
  - Reset mid-byte: the FSM returns to ARB immediately. The core is reset by the same rst.
- req_ready, tx_start and timeout_pulse are registered outputs and never high for more than one consecutive cycle.

Optional Feature:
UART_TX_ARB_TAG_EN
- Defined: adds a TAG state between ARB and the first ACCEPT of each packet. TAG issues one extra core byte, 8'hA0 | grant_id, via the same ISSUE/WAIT_HI/WAIT_LO sequence, then proceeds to ACCEPT. The tag byte never asserts req_ready and never ends the packet.
- Undefined: no TAG state; the output byte stream is exactly the requesters' bytes.

Test Plan:
- Req0 sends one byte 8'h55 with last=1, core model busy for 10 cycles -> req_ready[0] 1 cycle after valid; tx_start with tx_data=8'h55 2 cycles after valid; grant_valid drops after busy falls.
- Req1 sends 3-byte packet 11,22,33 while req2 is valid with 8'h99 last -> line order 11,22,33,99; no interleave; grant_id 1 then 2.
- All four valid with single-byte packets, repeated -> grant order 0,1,2,3,0,1 after reset.
- Req3 sends a non-last byte then stalls, HOLD_TIMEOUT=8 -> timeout_pulse 8 cycles after busy falls; next grant goes to req0 if it is valid.
- Assert rst while in WAIT_LO mid-packet -> all outputs return to reset values asynchronously; after release the next valid requester is granted, with req0 checked first.
- With UART_TX_ARB_TAG_EN, req2 sends 8'h41 last -> line bytes A2 then 41; req_ready[2] pulses exactly once.
